// File: rtl/mem_port_arb_if.sv
// Bundle of the core-facing fetch/load-store ports and the unified memory
// port handled by mem_port_arb. The slave modport is the arbiter's view.
// The master modport is the view of whatever drives the core and memory sides.
interface mem_port_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic [ADDR_W-1:0] imem_addr;
  logic [MASK_W-1:0] imem_rmask;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_resp;

  logic [ADDR_W-1:0] dmem_addr;
  logic [MASK_W-1:0] dmem_rmask;
  logic [MASK_W-1:0] dmem_wmask;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_resp;

  logic [ADDR_W-1:0] mem_addr;
  logic [MASK_W-1:0] mem_rmask;
  logic [MASK_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  imem_addr, imem_rmask,
    output imem_rdata, imem_resp,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp,
    output mem_addr, mem_rmask, mem_wmask, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output imem_addr, imem_rmask,
    input  imem_rdata, imem_resp,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp,
    input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_port_arb.sv
// Merges the core's fetch and load/store ports onto one memory port.
// Each side has a one-entry pending buffer. Only one transaction is ever
// outstanding downstream. Ties go to the port that was not granted last.
// A request is eligible for grant in the same cycle it is presented, and so
// is the cycle in which the outstanding response returns. This gives the
// one-cycle request-to-issue and response-to-next-issue latencies.
module mem_port_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_port_arb_if.slave  bus
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} port_t;

  state_t state, state_next;
  port_t  last_grant;

  logic              i_pend, d_pend;
  logic [ADDR_W-1:0] i_addr_q, d_addr_q;
  logic [MASK_W-1:0] i_rmask_q, d_rmask_q, d_wmask_q;
  logic [DATA_W-1:0] d_wdata_q;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [MASK_W-1:0] mem_rmask_q, mem_wmask_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic i_req, d_req, i_avail, d_avail;
  logic can_grant, grant_i, grant_d;

  logic [ADDR_W-1:0] i_addr_eff, d_addr_eff;
  logic [MASK_W-1:0] i_rmask_eff, d_rmask_eff, d_wmask_eff;
  logic [DATA_W-1:0] d_wdata_eff;

  assign i_req   = |bus.imem_rmask;
  assign d_req   = (|bus.dmem_rmask) | (|bus.dmem_wmask);
  assign i_avail = i_pend | i_req;
  assign d_avail = d_pend | d_req;

  assign i_addr_eff  = i_pend ? i_addr_q  : bus.imem_addr;
  assign i_rmask_eff = i_pend ? i_rmask_q : bus.imem_rmask;
  assign d_addr_eff  = d_pend ? d_addr_q  : bus.dmem_addr;
  assign d_rmask_eff = d_pend ? d_rmask_q : bus.dmem_rmask;
  assign d_wmask_eff = d_pend ? d_wmask_q : bus.dmem_wmask;
  assign d_wdata_eff = d_pend ? d_wdata_q : bus.dmem_wdata;

  // Arbitration and next state: the port is free when idle or when the response lands
  always_comb begin
    state_next = state;
    can_grant  = 1'b0;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE:           can_grant = 1'b1;
      WAIT_I, WAIT_D: can_grant = bus.mem_resp;
      default:        state_next = IDLE;
    endcase
    if (can_grant) begin
      if (i_avail && d_avail) begin
        if (last_grant == GRANT_I) grant_d = 1'b1;
        else                       grant_i = 1'b1;
      end else if (d_avail) begin
        grant_d = 1'b1;
      end else if (i_avail) begin
        grant_i = 1'b1;
      end
    end
    if (grant_d)                              state_next = WAIT_D;
    else if (grant_i)                         state_next = WAIT_I;
    else if (state != IDLE && bus.mem_resp)   state_next = IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Pending buffers: capture any request not granted straight through, clear on grant
  always_ff @(posedge clk) begin
    if (rst) begin
      i_pend    <= 1'b0;
      d_pend    <= 1'b0;
      i_addr_q  <= '0;
      i_rmask_q <= '0;
      d_addr_q  <= '0;
      d_rmask_q <= '0;
      d_wmask_q <= '0;
      d_wdata_q <= '0;
    end else begin
      if (grant_i) begin
        i_pend <= 1'b0;
      end else if (i_req) begin
        i_pend    <= 1'b1;
        i_addr_q  <= bus.imem_addr;
        i_rmask_q <= bus.imem_rmask;
      end
      if (grant_d) begin
        d_pend <= 1'b0;
      end else if (d_req) begin
        d_pend    <= 1'b1;
        d_addr_q  <= bus.dmem_addr;
        d_rmask_q <= bus.dmem_rmask;
        d_wmask_q <= bus.dmem_wmask;
        d_wdata_q <= bus.dmem_wdata;
      end
    end
  end

  // Downstream request registers: masks pulse for one cycle per grant
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_rmask_q <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      last_grant  <= GRANT_I;
    end else begin
      mem_rmask_q <= '0;
      mem_wmask_q <= '0;
      if (grant_d) begin
        mem_addr_q  <= d_addr_eff;
        mem_rmask_q <= d_rmask_eff;
        mem_wmask_q <= d_wmask_eff;
        mem_wdata_q <= d_wdata_eff;
        last_grant  <= GRANT_D;
      end else if (grant_i) begin
        mem_addr_q  <= i_addr_eff;
        mem_rmask_q <= i_rmask_eff;
        last_grant  <= GRANT_I;
      end
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rmask = mem_rmask_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.imem_resp  = bus.mem_resp & (state == WAIT_I) & ~rst;
  assign bus.dmem_resp  = bus.mem_resp & (state == WAIT_D) & ~rst;
  assign bus.imem_rdata = bus.mem_rdata;
  assign bus.dmem_rdata = bus.mem_rdata;

  // Protocol checks: one outstanding request per port, exclusive D masks, no stray responses
  a_i_single: assert property (@(posedge clk) disable iff (rst)
    i_req |-> !(i_pend || (state == WAIT_I && !bus.mem_resp)));
  a_d_single: assert property (@(posedge clk) disable iff (rst)
    d_req |-> !(d_pend || (state == WAIT_D && !bus.mem_resp)));
  a_d_rw_excl: assert property (@(posedge clk) disable iff (rst)
    !((|bus.dmem_rmask) && (|bus.dmem_wmask)));
  a_resp_idle: assert property (@(posedge clk) disable iff (rst)
    !(bus.mem_resp && state == IDLE));
endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios with fixed
// expectations, then random traffic checked against a transaction-level model.
module tb_mem_port_arb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [3:0]  s_i_rmask = '0, s_d_rmask = '0, s_d_wmask = '0;
  logic [31:0] s_i_addr = '0, s_d_addr = '0, s_d_wdata = '0, s_m_rdata = '0;
  logic        s_m_resp = 1'b0, s_rst = 1'b0;

  mem_port_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // One cycle: apply staged inputs at the falling edge, clear the staging, settle
  task automatic step();
    @(negedge clk);
    rst            = s_rst;
    bus.imem_rmask = s_i_rmask;
    bus.imem_addr  = s_i_addr;
    bus.dmem_rmask = s_d_rmask;
    bus.dmem_wmask = s_d_wmask;
    bus.dmem_addr  = s_d_addr;
    bus.dmem_wdata = s_d_wdata;
    bus.mem_resp   = s_m_resp;
    bus.mem_rdata  = s_m_rdata;
    s_i_rmask = '0; s_d_rmask = '0; s_d_wmask = '0;
    s_m_resp  = 1'b0; s_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    s_rst = 1'b1; s_m_resp = 1'b1; s_m_rdata = 32'hFFFF_FFFF;
    step();
    n_checks++;
    if ({bus.mem_addr, bus.mem_rmask, bus.mem_wmask, bus.mem_wdata} !== 72'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_mem: got %h/%h/%h/%h expected all zero", bus.mem_addr, bus.mem_rmask, bus.mem_wmask, bus.mem_wdata);
    end
    n_checks++;
    if ({bus.imem_resp, bus.dmem_resp} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_resp: got %b expected 00", {bus.imem_resp, bus.dmem_resp});
    end
    step();
  endtask

  task automatic test_single_fetch();
    s_i_rmask = 4'hF; s_i_addr = 32'h1ECE_B000;
    step();
    n_checks++;
    if (bus.mem_rmask !== 4'h0) begin
      n_fail++; $display("[TB] FAIL fetch_early: rmask got %h expected 0", bus.mem_rmask);
    end
    step();
    n_checks++;
    if ({bus.mem_rmask, bus.mem_wmask, bus.mem_addr} !== {4'hF, 4'h0, 32'h1ECE_B000}) begin
      n_fail++; $display("[TB] FAIL fetch_issue: got %h %h %h expected F 0 1eceb000", bus.mem_rmask, bus.mem_wmask, bus.mem_addr);
    end
    step();
    n_checks++;
    if (bus.mem_rmask !== 4'h0) begin
      n_fail++; $display("[TB] FAIL fetch_pulse: rmask got %h expected 0", bus.mem_rmask);
    end
    step();
    s_m_resp = 1'b1; s_m_rdata = 32'h0000_0013;
    step();
    n_checks++;
    if ({bus.imem_resp, bus.dmem_resp, bus.imem_rdata} !== {1'b1, 1'b0, 32'h0000_0013}) begin
      n_fail++; $display("[TB] FAIL fetch_resp: got %b %b %h expected 1 0 00000013", bus.imem_resp, bus.dmem_resp, bus.imem_rdata);
    end
    step();
    n_checks++;
    if (bus.imem_resp !== 1'b0) begin
      n_fail++; $display("[TB] FAIL fetch_resp_pulse: got %b expected 0", bus.imem_resp);
    end
  endtask

  task automatic test_simultaneous();
    s_i_rmask = 4'hF; s_i_addr = 32'h1000; s_d_rmask = 4'h3; s_d_addr = 32'h2000;
    step();
    step();
    n_checks++;
    if ({bus.mem_rmask, bus.mem_addr} !== {4'h3, 32'h2000}) begin
      n_fail++; $display("[TB] FAIL simul_first: got %h %h expected 3 00002000", bus.mem_rmask, bus.mem_addr);
    end
    step();
    s_m_resp = 1'b1; s_m_rdata = 32'hAAAA_5555;
    step();
    n_checks++;
    if ({bus.imem_resp, bus.dmem_resp, bus.dmem_rdata} !== {1'b0, 1'b1, 32'hAAAA_5555}) begin
      n_fail++; $display("[TB] FAIL simul_dresp: got %b %b %h expected 0 1 aaaa5555", bus.imem_resp, bus.dmem_resp, bus.dmem_rdata);
    end
    step();
    n_checks++;
    if ({bus.mem_rmask, bus.mem_addr} !== {4'hF, 32'h1000}) begin
      n_fail++; $display("[TB] FAIL simul_second: got %h %h expected F 00001000", bus.mem_rmask, bus.mem_addr);
    end
    s_m_resp = 1'b1; s_m_rdata = 32'h1234_5678;
    step();
    n_checks++;
    if ({bus.imem_resp, bus.dmem_resp, bus.imem_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      n_fail++; $display("[TB] FAIL simul_iresp: got %b %b %h expected 1 0 12345678", bus.imem_resp, bus.dmem_resp, bus.imem_rdata);
    end
  endtask

  task automatic test_store();
    s_d_wmask = 4'hC; s_d_wdata = 32'hDEAD_BEEF; s_d_addr = 32'h3004;
    step();
    step();
    n_checks++;
    if ({bus.mem_wmask, bus.mem_rmask, bus.mem_wdata, bus.mem_addr} !== {4'hC, 4'h0, 32'hDEAD_BEEF, 32'h3004}) begin
      n_fail++; $display("[TB] FAIL store_issue: got %h %h %h %h expected C 0 deadbeef 00003004", bus.mem_wmask, bus.mem_rmask, bus.mem_wdata, bus.mem_addr);
    end
    step();
    n_checks++;
    if ({bus.mem_wmask, bus.mem_rmask} !== 8'h00) begin
      n_fail++; $display("[TB] FAIL store_pulse: got %h %h expected 0 0", bus.mem_wmask, bus.mem_rmask);
    end
    s_m_resp = 1'b1; s_m_rdata = 32'h5A5A_5A5A;
    step();
    n_checks++;
    if ({bus.imem_resp, bus.dmem_resp, bus.mem_rmask} !== {1'b0, 1'b1, 4'h0}) begin
      n_fail++; $display("[TB] FAIL store_resp: got %b %b %h expected 0 1 0", bus.imem_resp, bus.dmem_resp, bus.mem_rmask);
    end
  endtask

  task automatic test_capture_busy();
    s_i_rmask = 4'hF; s_i_addr = 32'h5000;
    step();
    s_d_rmask = 4'hF; s_d_addr = 32'h4000;
    step();
    n_checks++;
    if ({bus.mem_rmask, bus.mem_addr} !== {4'hF, 32'h5000}) begin
      n_fail++; $display("[TB] FAIL busy_fetch: got %h %h expected F 00005000", bus.mem_rmask, bus.mem_addr);
    end
    step();
    n_checks++;
    if (bus.mem_rmask !== 4'h0) begin
      n_fail++; $display("[TB] FAIL busy_hold: rmask got %h expected 0", bus.mem_rmask);
    end
    s_m_resp = 1'b1; s_m_rdata = 32'h0BAD_F00D;
    step();
    n_checks++;
    if ({bus.imem_resp, bus.dmem_resp} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL busy_iresp: got %b expected 10", {bus.imem_resp, bus.dmem_resp});
    end
    step();
    n_checks++;
    if ({bus.mem_rmask, bus.mem_addr} !== {4'hF, 32'h4000}) begin
      n_fail++; $display("[TB] FAIL busy_load: got %h %h expected F 00004000", bus.mem_rmask, bus.mem_addr);
    end
    s_m_resp = 1'b1; s_m_rdata = 32'h7777_0000;
    s_i_rmask = 4'h7; s_i_addr = 32'h6000;
    step();
    n_checks++;
    if ({bus.imem_resp, bus.dmem_resp, bus.dmem_rdata} !== {1'b0, 1'b1, 32'h7777_0000}) begin
      n_fail++; $display("[TB] FAIL busy_dresp: got %b %b %h expected 0 1 77770000", bus.imem_resp, bus.dmem_resp, bus.dmem_rdata);
    end
    step();
    n_checks++;
    if ({bus.mem_rmask, bus.mem_addr} !== {4'h7, 32'h6000}) begin
      n_fail++; $display("[TB] FAIL busy_resp_capture: got %h %h expected 7 00006000", bus.mem_rmask, bus.mem_addr);
    end
    s_m_resp = 1'b1;
    step();
  endtask

  task automatic test_fairness();
    logic [31:0] ia, da;
    ia = $urandom; da = $urandom;
    s_i_rmask = 4'hF; s_i_addr = ia; s_d_rmask = 4'h3; s_d_addr = da;
    step();
    for (int k = 0; k < 8; k++) begin
      logic exp_d;
      exp_d = (k % 2 == 0);
      step();
      n_checks++;
      if ({bus.mem_rmask, bus.mem_addr} !== (exp_d ? {4'h3, da} : {4'hF, ia})) begin
        n_fail++; $display("[TB] FAIL fair_grant%0d: got %h %h expected port %s", k, bus.mem_rmask, bus.mem_addr, exp_d ? "D" : "I");
      end
      repeat ($urandom_range(0, 2)) step();
      s_m_resp = 1'b1; s_m_rdata = $urandom;
      if (k < 6) begin
        if (exp_d) begin da = $urandom; s_d_rmask = 4'h3; s_d_addr = da; end
        else       begin ia = $urandom; s_i_rmask = 4'hF; s_i_addr = ia; end
      end
      step();
      n_checks++;
      if ({bus.imem_resp, bus.dmem_resp} !== {~exp_d, exp_d}) begin
        n_fail++; $display("[TB] FAIL fair_resp%0d: got %b expected %b", k, {bus.imem_resp, bus.dmem_resp}, {~exp_d, exp_d});
      end
    end
  endtask

  task automatic test_reset_mid();
    s_d_rmask = 4'hF; s_d_addr = 32'h7000;
    step();
    s_i_rmask = 4'hF; s_i_addr = 32'h8000;
    step();
    n_checks++;
    if ({bus.mem_rmask, bus.mem_addr} !== {4'hF, 32'h7000}) begin
      n_fail++; $display("[TB] FAIL rmid_load: got %h %h expected F 00007000", bus.mem_rmask, bus.mem_addr);
    end
    s_rst = 1'b1; s_m_resp = 1'b1; s_m_rdata = 32'hCAFE_0000;
    step();
    n_checks++;
    if ({bus.imem_resp, bus.dmem_resp} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL rmid_resp_in_reset: got %b expected 00", {bus.imem_resp, bus.dmem_resp});
    end
    step();
    n_checks++;
    if ({bus.mem_addr, bus.mem_rmask, bus.mem_wmask, bus.mem_wdata, bus.imem_resp, bus.dmem_resp} !== 74'h0) begin
      n_fail++; $display("[TB] FAIL rmid_cleared: got %h %h %h %h %b%b expected all zero", bus.mem_addr, bus.mem_rmask, bus.mem_wmask, bus.mem_wdata, bus.imem_resp, bus.dmem_resp);
    end
    step();
    n_checks++;
    if ({bus.mem_rmask, bus.mem_wmask} !== 8'h00) begin
      n_fail++; $display("[TB] FAIL rmid_no_stale: got %h %h expected 0 0", bus.mem_rmask, bus.mem_wmask);
    end
    s_i_rmask = 4'hF; s_i_addr = 32'h9000;
    step();
    step();
    n_checks++;
    if ({bus.mem_rmask, bus.mem_addr} !== {4'hF, 32'h9000}) begin
      n_fail++; $display("[TB] FAIL rmid_new_fetch: got %h %h expected F 00009000", bus.mem_rmask, bus.mem_addr);
    end
    s_m_resp = 1'b1;
    step();
    n_checks++;
    if ({bus.imem_resp, bus.dmem_resp} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL rmid_iresp: got %b expected 10", {bus.imem_resp, bus.dmem_resp});
    end
    step();
    n_checks++;
    if ({bus.mem_rmask, bus.mem_wmask} !== 8'h00) begin
      n_fail++; $display("[TB] FAIL rmid_no_stale_d: got %h %h expected 0 0", bus.mem_rmask, bus.mem_wmask);
    end
  endtask

  task automatic test_random(input int n_cycles);
    txn_t        i_q[$], d_q[$];
    txn_t        exp_issue;
    logic        exp_valid, busy, busy_d, last_d;
    int          cd;
    exp_valid = 1'b0; busy = 1'b0; busy_d = 1'b0; last_d = 1'b0; cd = 0;
    exp_issue = '{default: '0};
    s_rst = 1'b1;
    step();
    for (int c = 0; c < n_cycles; c++) begin
      logic        m_resp, i_free, d_free, gen, pick_d;
      logic [31:0] rd;
      txn_t        t;
      if (busy && cd > 0) cd--;
      m_resp = busy && (cd == 0);
      i_free = (i_q.size() == 0) && !(busy && !busy_d && !m_resp);
      d_free = (d_q.size() == 0) && !(busy && busy_d && !m_resp);
      gen    = (c < n_cycles - 30);
      if (gen && i_free && $urandom_range(0, 99) < 40) begin
        t.addr = $urandom; t.rmask = 4'($urandom_range(1, 15)); t.wmask = '0; t.wdata = '0;
        s_i_rmask = t.rmask; s_i_addr = t.addr;
        i_q.push_back(t);
      end
      if (gen && d_free && $urandom_range(0, 99) < 40) begin
        t.addr = $urandom; t.wdata = $urandom;
        if ($urandom_range(0, 1) == 1) begin t.rmask = '0; t.wmask = 4'($urandom_range(1, 15)); end
        else                           begin t.wmask = '0; t.rmask = 4'($urandom_range(1, 15)); end
        s_d_rmask = t.rmask; s_d_wmask = t.wmask; s_d_addr = t.addr; s_d_wdata = t.wdata;
        d_q.push_back(t);
      end
      rd = $urandom;
      s_m_resp = m_resp; s_m_rdata = rd;
      step();
      n_checks++;
      if (exp_valid) begin
        if ({bus.mem_rmask, bus.mem_wmask, bus.mem_addr} !== {exp_issue.rmask, exp_issue.wmask, exp_issue.addr}) begin
          n_fail++; $display("[TB] FAIL rand_issue c%0d: got %h %h %h expected %h %h %h", c, bus.mem_rmask, bus.mem_wmask, bus.mem_addr, exp_issue.rmask, exp_issue.wmask, exp_issue.addr);
        end
        if (exp_issue.wmask != 4'h0) begin
          n_checks++;
          if (bus.mem_wdata !== exp_issue.wdata) begin
            n_fail++; $display("[TB] FAIL rand_wdata c%0d: got %h expected %h", c, bus.mem_wdata, exp_issue.wdata);
          end
        end
      end else if ({bus.mem_rmask, bus.mem_wmask} !== 8'h00) begin
        n_fail++; $display("[TB] FAIL rand_quiet c%0d: got %h %h expected 0 0", c, bus.mem_rmask, bus.mem_wmask);
      end
      n_checks++;
      if ({bus.imem_resp, bus.dmem_resp} !== {m_resp & ~busy_d, m_resp & busy_d}) begin
        n_fail++; $display("[TB] FAIL rand_resp c%0d: got %b expected %b", c, {bus.imem_resp, bus.dmem_resp}, {m_resp & ~busy_d, m_resp & busy_d});
      end
      if (m_resp) begin
        n_checks++;
        if ((busy_d ? bus.dmem_rdata : bus.imem_rdata) !== rd) begin
          n_fail++; $display("[TB] FAIL rand_rdata c%0d: got %h expected %h", c, busy_d ? bus.dmem_rdata : bus.imem_rdata, rd);
        end
        busy = 1'b0;
      end
      exp_valid = 1'b0;
      if (!busy && (i_q.size() > 0 || d_q.size() > 0)) begin
        if (i_q.size() > 0 && d_q.size() > 0) pick_d = ~last_d;
        else                                  pick_d = (d_q.size() > 0);
        exp_issue = pick_d ? d_q.pop_front() : i_q.pop_front();
        exp_valid = 1'b1; busy = 1'b1; busy_d = pick_d; last_d = pick_d;
        cd = $urandom_range(2, 5);
      end
    end
  endtask

  // Scenario sequence followed by the summary
  initial begin
    bus.imem_rmask = '0; bus.imem_addr = '0;
    bus.dmem_rmask = '0; bus.dmem_wmask = '0; bus.dmem_addr = '0; bus.dmem_wdata = '0;
    bus.mem_resp = 1'b0; bus.mem_rdata = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store();
    test_capture_busy();
    test_fairness();
    test_reset_mid();
    test_random(600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
